neuron_fire_fsm: RTL and testbench
==================================

Name: neuron_fire_fsm

Overview:
- Downstream stage of the sequential 10-input accumulator (tgfa_10bit adder + ff10 registers).
- Takes the 11-bit frame sum (10-bit sum plus carry) when the accumulator signals that a frame has completed.
- Integrates the sum into a leaky membrane-potential register and fires a one-cycle spike when the potential reaches threshold.
- Enforces a refractory period after each spike and counts spikes.
- Pure digital logic ports; the bench converts from xreal with xreal_to_bit.

Parameters:
- SUM_W, 11, width of incoming frame sum (carry + 10-bit sum).
- VM_W, 12, membrane-potential width; must satisfy VM_W > SUM_W.
- THRESH, 1000, firing threshold; legal range 1 .. 2^VM_W-1.
- LEAK_SHIFT, 0, leak = VMEM >> LEAK_SHIFT; 0 disables leak.
- REFRAC_CYC, 3, refractory length in cycles; 0 allowed.
- CNT_W, 8, spike counter width.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- SUM_VALID  in  1  one-cycle strobe: SUM holds a completed frame sum.
- SUM  in  SUM_W  accumulated frame sum, unsigned {Cout, Sout[9:0]}.
- SPIKE  out  1  registered fire pulse, exactly 1 cycle wide.
- VMEM  out  VM_W  current membrane potential, registered.
- REFRAC_ACT  out  1  high while in REFRAC state.
- DROP  out  1  registered pulse: the SUM_VALID of the previous cycle was discarded.
- SPIKE_CNT  out  CNT_W  saturating total spike count.

Behaviour:
- **Interface:** one clock, CK; reset is synchronous and active-high (RST). All outputs are registered.
- **Reset:** RST sampled high at a CK rising edge overrides everything, including an in-flight FIRE or REFRAC. Next state is IDLE.
  - SPIKE=0, VMEM=0, REFRAC_ACT=0, DROP=0, SPIKE_CNT=0, refractory counter=0.
- **States:** IDLE, FIRE, REFRAC.
- **IDLE, SUM_VALID=0:** hold VMEM; SPIKE=0, DROP=0.
- **IDLE, SUM_VALID=1:**
  - Compute cand = VMEM - leak + zero-extended SUM, in VM_W+1 bits.
  - leak = 0 when LEAK_SHIFT=0, otherwise VMEM >> LEAK_SHIFT.
  - Saturate cand to 2^VM_W-1 (cand never goes negative, since leak <= VMEM).
  - If cand >= THRESH: go to FIRE, VMEM<=0, SPIKE<=1, SPIKE_CNT<=SPIKE_CNT+1 (held at 2^CNT_W-1 once reached).
  - Otherwise: VMEM<=cand, stay in IDLE.
- **Latency:** SPIKE is high in the cycle after the edge that sampled the triggering SUM_VALID.
- **FIRE** lasts one cycle with SPIKE=1.
  - Next state is REFRAC with counter=REFRAC_CYC, REFRAC_ACT<=1, SPIKE<=0.
  - If REFRAC_CYC=0, next state is IDLE directly.
- **REFRAC:**
  - VMEM held at 0, REFRAC_ACT=1.
  - Counter decrements each cycle; on the edge where the counter is 1, go to IDLE and set REFRAC_ACT<=0.
  - REFRAC_ACT is therefore high for exactly REFRAC_CYC cycles.
- **Drops:** SUM_VALID sampled in FIRE or REFRAC is discarded and DROP<=1 for one cycle. VMEM and SPIKE_CNT are unaffected.
- **Back-to-back SUM_VALID in IDLE:** every strobe is integrated, one per cycle, with no bubbles.
- **No buffering:** dropped sums are never replayed.

Test Plan:
1. Integration to fire (defaults): SUM=400 strobes on 3 separate cycles.
   - Required: VMEM 400, then 800; third strobe gives cand=1200.
   - Next cycle: SPIKE=1, VMEM=0, SPIKE_CNT=1; REFRAC_ACT high for 3 cycles.
2. Refractory drops: SUM=2047 with SUM_VALID held high continuously.
   - Required: fires on first strobe.
   - DROP high for 4 consecutive cycles (FIRE + 3 REFRAC).
   - 5th strobe accepted and fires again: spike period = 5 cycles.
3. Leak (LEAK_SHIFT=2): VMEM=800 then SUM=0 strobe -> VMEM=600. Then SUM=100 -> VMEM=550, no spike.
4. Saturation (THRESH=4095): VMEM=3000 then SUM=2047 -> cand saturates to 4095 -> SPIKE=1, VMEM=0.
5. Reset mid-operation: RST=1 for 1 cycle during the 2nd REFRAC cycle.
   - Required: next cycle all outputs 0, REFRAC_ACT=0.
   - A following SUM=400 strobe is integrated (VMEM=400, DROP=0).
   - Also: RST asserted together with a firing SUM_VALID gives SPIKE=0.
6. Counter saturation: REFRAC_CYC=0, SUM=2047 every cycle for 600 cycles -> SPIKE_CNT stops at 255, never wraps to 0.

Source files
------------

// File: rtl/neuron_fire_fsm.sv
// Leaky integrate-and-fire stage fed by the 10-input frame accumulator.
// Integrates each completed frame sum, fires a one-cycle spike at threshold, then goes refractory.
module neuron_fire_fsm #(
  parameter int SUM_W      = 11,
  parameter int VM_W       = 12,
  parameter int THRESH     = 1000,
  parameter int LEAK_SHIFT = 0,
  parameter int REFRAC_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             SUM_VALID,
  input  logic [SUM_W-1:0] SUM,
  output logic             SPIKE,
  output logic [VM_W-1:0]  VMEM,
  output logic             REFRAC_ACT,
  output logic             DROP,
  output logic [CNT_W-1:0] SPIKE_CNT
);

  localparam int RC_W = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC + 1) : 1;
  localparam logic [VM_W-1:0] THR  = VM_W'(THRESH);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRAC_CYC);

  if (VM_W <= SUM_W) begin : g_bad_width
    $error("neuron_fire_fsm: VM_W must exceed SUM_W");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    REFRAC = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [RC_W-1:0]  rc_cnt, rc_cnt_nxt;
  logic [VM_W-1:0]  vmem_nxt;
  logic             spike_nxt, refrac_nxt, drop_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [VM_W:0]    cand;
  logic [VM_W-1:0]  cand_sat;
  logic             fire;

  function automatic logic [VM_W-1:0] leak_of(input logic [VM_W-1:0] v);
    if (LEAK_SHIFT == 0) return '0;
    return v >> LEAK_SHIFT;
  endfunction

  function automatic logic [VM_W-1:0] sat_vmem(input logic [VM_W:0] c);
    return c[VM_W] ? {VM_W{1'b1}} : c[VM_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Leak never exceeds VMEM, so the extra top bit only ever holds overflow from the sum.
  always_comb begin
    cand     = {1'b0, VMEM} - {1'b0, leak_of(VMEM)} + (VM_W+1)'(SUM);
    cand_sat = sat_vmem(cand);
    fire     = (cand_sat >= THR);
  end

  always_comb begin
    state_nxt  = state;
    rc_cnt_nxt = rc_cnt;
    vmem_nxt   = VMEM;
    spike_nxt  = 1'b0;
    refrac_nxt = 1'b0;
    drop_nxt   = 1'b0;
    cnt_nxt    = SPIKE_CNT;
    case (state)
      IDLE: begin
        if (SUM_VALID) begin
          if (fire) begin
            state_nxt = FIRE;
            vmem_nxt  = '0;
            spike_nxt = 1'b1;
            cnt_nxt   = sat_inc(SPIKE_CNT);
          end else begin
            vmem_nxt = cand_sat;
          end
        end
      end
      FIRE: begin
        drop_nxt = SUM_VALID;
        if (REFRAC_CYC == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt  = REFRAC;
          rc_cnt_nxt = RC_LOAD;
          refrac_nxt = 1'b1;
        end
      end
      REFRAC: begin
        // Strobes landing here are lost for good; there is no replay buffer.
        drop_nxt = SUM_VALID;
        if (rc_cnt <= RC_W'(1)) begin
          state_nxt  = IDLE;
          rc_cnt_nxt = '0;
        end else begin
          rc_cnt_nxt = rc_cnt - RC_W'(1);
          refrac_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        rc_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state      <= IDLE;
      rc_cnt     <= '0;
      VMEM       <= '0;
      SPIKE      <= 1'b0;
      REFRAC_ACT <= 1'b0;
      DROP       <= 1'b0;
      SPIKE_CNT  <= '0;
    end else begin
      state      <= state_nxt;
      rc_cnt     <= rc_cnt_nxt;
      VMEM       <= vmem_nxt;
      SPIKE      <= spike_nxt;
      REFRAC_ACT <= refrac_nxt;
      DROP       <= drop_nxt;
      SPIKE_CNT  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_neuron_fire_fsm.sv
// Four neuron configurations driven by shared stimulus, each compared every cycle against a
// cycle-budget reference model, plus directed scenarios with hand-derived constants.
module tb_neuron_fire_fsm;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        SUM_VALID = 1'b0;
  logic [10:0] SUM = '0;

  logic        spike [4];
  logic [11:0] vmem  [4];
  logic        refr  [4];
  logic        drop  [4];
  logic [7:0]  cnt   [4];

  always #5 CK = ~CK;

  // 0: defaults, 1: leak shift 2, 2: threshold 4095, 3: no refractory
  neuron_fire_fsm u_def (.CK(CK), .RST(RST), .SUM_VALID(SUM_VALID), .SUM(SUM),
    .SPIKE(spike[0]), .VMEM(vmem[0]), .REFRAC_ACT(refr[0]), .DROP(drop[0]), .SPIKE_CNT(cnt[0]));
  neuron_fire_fsm #(.LEAK_SHIFT(2)) u_leak (.CK(CK), .RST(RST), .SUM_VALID(SUM_VALID), .SUM(SUM),
    .SPIKE(spike[1]), .VMEM(vmem[1]), .REFRAC_ACT(refr[1]), .DROP(drop[1]), .SPIKE_CNT(cnt[1]));
  neuron_fire_fsm #(.THRESH(4095)) u_sat (.CK(CK), .RST(RST), .SUM_VALID(SUM_VALID), .SUM(SUM),
    .SPIKE(spike[2]), .VMEM(vmem[2]), .REFRAC_ACT(refr[2]), .DROP(drop[2]), .SPIKE_CNT(cnt[2]));
  neuron_fire_fsm #(.REFRAC_CYC(0)) u_norf (.CK(CK), .RST(RST), .SUM_VALID(SUM_VALID), .SUM(SUM),
    .SPIKE(spike[3]), .VMEM(vmem[3]), .REFRAC_ACT(refr[3]), .DROP(drop[3]), .SPIKE_CNT(cnt[3]));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference model: after a fire the neuron is unavailable for 1+REFRAC_CYC edges.
  int thr_m [4] = '{1000, 1000, 4095, 1000};
  int ls_m  [4] = '{0, 2, 0, 0};
  int rc_m  [4] = '{3, 3, 3, 0};
  int m_vmem [4];
  int m_cnt  [4];
  int m_busy [4];
  int m_spike[4];
  int m_drop [4];
  int m_refr [4];
  bit chk_en = 1'b0;

  always @(posedge CK) begin
    for (int g = 0; g < 4; g++) begin
      int leak, cand;
      m_spike[g] = 0;
      m_drop[g]  = 0;
      if (RST) begin
        m_vmem[g] = 0; m_cnt[g] = 0; m_busy[g] = 0;
      end else if (m_busy[g] > 0) begin
        m_drop[g] = int'(SUM_VALID);
        m_busy[g]--;
      end else if (SUM_VALID) begin
        leak = (ls_m[g] == 0) ? 0 : (m_vmem[g] >> ls_m[g]);
        cand = m_vmem[g] - leak + int'(SUM);
        if (cand > 4095) cand = 4095;
        if (cand >= thr_m[g]) begin
          m_vmem[g]  = 0;
          m_spike[g] = 1;
          m_busy[g]  = 1 + rc_m[g];
          if (m_cnt[g] < 255) m_cnt[g]++;
        end else begin
          m_vmem[g] = cand;
        end
      end
      m_refr[g] = (m_busy[g] > 0 && m_spike[g] == 0) ? 1 : 0;
    end
  end

  always @(negedge CK) begin
    if (chk_en) begin
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("m%0d_spike", g), int'(spike[g]), m_spike[g]);
        chk($sformatf("m%0d_vmem", g),  int'(vmem[g]),  m_vmem[g]);
        chk($sformatf("m%0d_refr", g),  int'(refr[g]),  m_refr[g]);
        chk($sformatf("m%0d_drop", g),  int'(drop[g]),  m_drop[g]);
        chk($sformatf("m%0d_cnt", g),   int'(cnt[g]),   m_cnt[g]);
      end
    end
  end

  task automatic cyc(input logic sv, input logic [10:0] s, input logic r);
    @(negedge CK);
    SUM_VALID = sv;
    SUM       = s;
    RST       = r;
    @(posedge CK);
    #1;
  endtask

  initial begin
    int prev_cnt;
    int wrapped;
    logic [10:0] rs;

    // reset state
    cyc(1'b0, 11'd0, 1'b1);
    chk_en = 1'b1;
    chk("rst_spike", int'(spike[0]), 0);
    chk("rst_vmem", int'(vmem[0]), 0);
    chk("rst_refr", int'(refr[0]), 0);
    chk("rst_drop", int'(drop[0]), 0);
    chk("rst_cnt", int'(cnt[0]), 0);

    // integration to fire
    cyc(1'b1, 11'd400, 1'b0);  chk("int_v400", int'(vmem[0]), 400);
    cyc(1'b0, 11'd0, 1'b0);    chk("int_hold", int'(vmem[0]), 400);
    cyc(1'b1, 11'd400, 1'b0);  chk("int_v800", int'(vmem[0]), 800);
    cyc(1'b1, 11'd400, 1'b0);
    chk("int_spike", int'(spike[0]), 1);
    chk("int_vzero", int'(vmem[0]), 0);
    chk("int_cnt1", int'(cnt[0]), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 11'd0, 1'b0);
      chk("int_refr_on", int'(refr[0]), 1);
      chk("int_spike_off", int'(spike[0]), 0);
    end
    cyc(1'b0, 11'd0, 1'b0);    chk("int_refr_off", int'(refr[0]), 0);

    // refractory drops with strobe held high
    cyc(1'b0, 11'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 11'd2047, 1'b0);
      chk("drp_spike", int'(spike[0]), (i % 5 == 0) ? 1 : 0);
      if (i > 0) chk("drp_drop", int'(drop[0]), (i % 5 != 0) ? 1 : 0);
      chk("drp_refr", int'(refr[0]), (i % 5 >= 1 && i % 5 <= 3) ? 1 : 0);
    end

    // leak on the LEAK_SHIFT=2 instance
    cyc(1'b0, 11'd0, 1'b1);
    cyc(1'b1, 11'd800, 1'b0);  chk("lk_v800", int'(vmem[1]), 800);
    cyc(1'b1, 11'd0, 1'b0);    chk("lk_v600", int'(vmem[1]), 600);
    cyc(1'b1, 11'd100, 1'b0);
    chk("lk_v550", int'(vmem[1]), 550);
    chk("lk_nospike", int'(spike[1]), 0);

    // saturation on the THRESH=4095 instance
    cyc(1'b0, 11'd0, 1'b1);
    cyc(1'b1, 11'd2047, 1'b0);
    cyc(1'b1, 11'd953, 1'b0);  chk("sat_v3000", int'(vmem[2]), 3000);
    cyc(1'b1, 11'd2047, 1'b0);
    chk("sat_spike", int'(spike[2]), 1);
    chk("sat_vzero", int'(vmem[2]), 0);

    // reset in the middle of refractory, then reset racing a firing strobe
    cyc(1'b0, 11'd0, 1'b1);
    cyc(1'b1, 11'd2047, 1'b0); chk("mr_fire", int'(spike[0]), 1);
    cyc(1'b0, 11'd0, 1'b0);    chk("mr_refr1", int'(refr[0]), 1);
    cyc(1'b0, 11'd0, 1'b0);    chk("mr_refr2", int'(refr[0]), 1);
    cyc(1'b0, 11'd0, 1'b1);
    chk("mr_refr", int'(refr[0]), 0);
    chk("mr_cnt", int'(cnt[0]), 0);
    chk("mr_spike", int'(spike[0]), 0);
    cyc(1'b1, 11'd400, 1'b0);
    chk("mr_v400", int'(vmem[0]), 400);
    chk("mr_nodrop", int'(drop[0]), 0);
    cyc(1'b1, 11'd2047, 1'b1);
    chk("mr_rst_spike", int'(spike[0]), 0);
    chk("mr_rst_vmem", int'(vmem[0]), 0);

    // counter saturation on the REFRAC_CYC=0 instance
    cyc(1'b0, 11'd0, 1'b1);
    prev_cnt = 0;
    wrapped  = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(1'b1, 11'd2047, 1'b0);
      if (int'(cnt[3]) < prev_cnt) wrapped = 1;
      prev_cnt = int'(cnt[3]);
    end
    chk("cnt_sat255", int'(cnt[3]), 255);
    chk("cnt_nowrap", wrapped, 0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rs = 11'(2047 - $urandom_range(0, 60));
      else rs = 11'($urandom_range(0, 600));
      cyc(1'($urandom_range(0, 99) < 65), rs, 1'($urandom_range(0, 99) == 0));
    end

    @(negedge CK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
